// File: rtl/speed_mode_ctrl_pkg.sv
// Shared definitions for the three-speed blink/tick controller.
//   - One-hot mode encodings (slow/mid/fast)
//   - Phase enum for the duty-cycle FSM
//   - Default phase durations and debounce length
//   - next_target(): saturating one-hot shift of the speed target
package speed_mode_ctrl_pkg;

  localparam logic [2:0] MODE_SLOW = 3'b001;
  localparam logic [2:0] MODE_MID  = 3'b010;
  localparam logic [2:0] MODE_FAST = 3'b100;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

  localparam int DEF_CNT_W      = 21;
  localparam int DEF_LOW_SLOW   = 30;
  localparam int DEF_HIGH_SLOW  = 60;
  localparam int DEF_LOW_MID    = 20;
  localparam int DEF_HIGH_MID   = 40;
  localparam int DEF_LOW_FAST   = 10;
  localparam int DEF_HIGH_FAST  = 20;
  localparam int DEF_DEB_CYCLES = 4;

  // Saturating shift of the one-hot target. Simultaneous up/down cancel.
  // Any non-legal encoding is first normalised to slow.
  function automatic logic [2:0] next_target(input logic [2:0] cur,
                                             input logic       up,
                                             input logic       down);
    logic [2:0] base;
    base = ((cur == MODE_MID) || (cur == MODE_FAST)) ? cur : MODE_SLOW;
    next_target = base;
    if (up && !down) begin
      case (base)
        MODE_SLOW: next_target = MODE_MID;
        default:   next_target = MODE_FAST;
      endcase
    end else if (down && !up) begin
      case (base)
        MODE_FAST: next_target = MODE_MID;
        default:   next_target = MODE_SLOW;
      endcase
    end
  endfunction

endpackage

// File: rtl/speed_mode_ctrl_if.sv
// Board-side bundle of the speed controller.
//   btn_up / btn_down : raw asynchronous push-buttons
//   clk_out           : duty-cycled divided output
//   mode              : applied one-hot mode
//   change_pending    : target differs from applied mode
//   period_done       : pulse in the last cycle of each high phase
// master = button/consumer side, slave = the controller.
interface speed_mode_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       clk_out;
  logic [2:0] mode;
  logic       change_pending;
  logic       period_done;

  modport master (
    output btn_up, btn_down,
    input  clk_out, mode, change_pending, period_done
  );

  modport slave (
    input  btn_up, btn_down,
    output clk_out, mode, change_pending, period_done
  );
endinterface

// File: rtl/speed_mode_ctrl_btn_debounce_edge.sv
// Button conditioning: 2-FF synchronizer, debounce, rising-edge pulse.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : raw asynchronous button level
//   req        : one-cycle pulse when the debounced level rises
// A new level is accepted once the synchronized sample has differed from
// the current debounced level on DEB_CYCLES consecutive edges.
module btn_debounce_edge #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int            DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic          stable;
  logic          stable_d;
  logic [DW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      s        <= sync1;
      stable_d <= stable;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  // Release (falling debounced level) deliberately produces nothing.
  assign req = stable & ~stable_d;

endmodule

// File: rtl/speed_mode_ctrl.sv
// Three-speed blink/tick controller.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : speed_mode_ctrl_if.slave (buttons in; clk_out, mode,
//                change_pending, period_done out)
// Button requests move a saturating one-hot target; the target is applied
// to mode only at the HIGH->LOW boundary so a phase is never cut short or
// stretched. Phase lengths come from the applied mode.
module speed_mode_ctrl
  import speed_mode_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOW_SLOW   = DEF_LOW_SLOW,
  parameter int HIGH_SLOW  = DEF_HIGH_SLOW,
  parameter int LOW_MID    = DEF_LOW_MID,
  parameter int HIGH_MID   = DEF_HIGH_MID,
  parameter int LOW_FAST   = DEF_LOW_FAST,
  parameter int HIGH_FAST  = DEF_HIGH_FAST,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  speed_mode_ctrl_if.slave  bus
);

  logic             up_req;
  logic             down_req;

  phase_e           phase_q, phase_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             clk_out_q, clk_out_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic [2:0]       target_q, target_nxt;
  logic [CNT_W-1:0] last_low, last_high;

  btn_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_up),
    .req   (up_req)
  );

  btn_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_down (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_down),
    .req   (down_req)
  );

  // Terminal counts of the applied mode; an illegal mode runs as slow.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    last_low  = CNT_W'(LOW_SLOW - 1);
    last_high = CNT_W'(HIGH_SLOW - 1);
    case (mode_q)
      MODE_MID: begin
        last_low  = CNT_W'(LOW_MID - 1);
        last_high = CNT_W'(HIGH_MID - 1);
      end
      MODE_FAST: begin
        last_low  = CNT_W'(LOW_FAST - 1);
        last_high = CNT_W'(HIGH_FAST - 1);
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_LOW;
      count_q   <= '0;
      clk_out_q <= 1'b0;
      mode_q    <= MODE_SLOW;
      target_q  <= MODE_SLOW;
    end else begin
      phase_q   <= phase_nxt;
      count_q   <= count_nxt;
      clk_out_q <= clk_out_nxt;
      mode_q    <= mode_nxt;
      target_q  <= target_nxt;
    end
  end

  // Next state. The commit reads target_q (pre-edge), so a request whose
  // target update lands on the boundary edge waits for the next period.
  always_comb begin
    phase_nxt   = phase_q;
    count_nxt   = count_q + CNT_W'(1);
    clk_out_nxt = clk_out_q;
    mode_nxt    = mode_q;
    target_nxt  = next_target(target_q, up_req, down_req);
    case (phase_q)
      PH_LOW: begin
        if (count_q == last_low) begin
          phase_nxt   = PH_HIGH;
          count_nxt   = '0;
          clk_out_nxt = 1'b1;
        end
      end
      PH_HIGH: begin
        if (count_q == last_high) begin
          phase_nxt   = PH_LOW;
          count_nxt   = '0;
          clk_out_nxt = 1'b0;
          mode_nxt    = target_q;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.clk_out        = clk_out_q;
    bus.mode           = mode_q;
    bus.change_pending = (target_q != mode_q);
    bus.period_done    = (phase_q == PH_HIGH) && (count_q == last_high);
  end

endmodule

// File: tb/tb_speed_mode_ctrl.sv
// Self-checking bench for speed_mode_ctrl: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural model built on period position and sample histories.
module tb_speed_mode_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  speed_mode_ctrl_if bus ();

  speed_mode_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode/target as index 0 slow, 1 mid, 2 fast; m_pos = cycle within period.
  function automatic int low_n(input int idx);
    return (idx == 2) ? 10 : (idx == 1) ? 20 : 30;
  endfunction
  function automatic int high_n(input int idx);
    return (idx == 2) ? 20 : (idx == 1) ? 40 : 60;
  endfunction

  int m_mode, m_tgt, m_pos;
  bit m_stab [2];
  bit m_pend [2];
  bit m_dly  [2][2];   // [button][0]=sampled last edge, [1]=two edges back
  bit m_hist [2][$];   // last DEB synchronized samples
  bit m_b    [2];
  bit m_s;
  bit m_all;

  always @(posedge clk) begin
    m_b[0] = bus.btn_up;
    m_b[1] = bus.btn_down;
    if (reset) begin
      m_mode = 0; m_tgt = 0; m_pos = 0;
      for (int i = 0; i < 2; i++) begin
        m_stab[i] = 0; m_pend[i] = 0;
        m_dly[i][0] = 0; m_dly[i][1] = 0;
        m_hist[i].delete();
      end
    end else begin
      if (m_pos == low_n(m_mode) + high_n(m_mode) - 1) begin
        m_mode = m_tgt;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
      if (m_pend[0] && !m_pend[1]) m_tgt = (m_tgt < 2) ? m_tgt + 1 : 2;
      else if (m_pend[1] && !m_pend[0]) m_tgt = (m_tgt > 0) ? m_tgt - 1 : 0;
      for (int i = 0; i < 2; i++) begin
        m_s = m_dly[i][1];
        m_dly[i][1] = m_dly[i][0];
        m_dly[i][0] = m_b[i];
        m_hist[i].push_back(m_s);
        if (m_hist[i].size() > DEB) void'(m_hist[i].pop_front());
        m_pend[i] = 0;
        if (m_hist[i].size() == DEB) begin
          m_all = 1;
          foreach (m_hist[i][k]) if (m_hist[i][k] == m_stab[i]) m_all = 0;
          if (m_all) begin
            m_stab[i] = !m_stab[i];
            m_pend[i] = m_stab[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("clk_out",        bus.clk_out,        32'(m_pos >= low_n(m_mode)));
      check("mode",           bus.mode,           32'(1) << m_mode);
      check("change_pending", bus.change_pending, 32'(m_tgt != m_mode));
      check("period_done",    bus.period_done,
            32'(m_pos == low_n(m_mode) + high_n(m_mode) - 1));
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;   // this negedge is cycle 0 after reset
  endtask

  task automatic press(input bit up, input bit down, input int hi, input int lo);
    bus.btn_up = up; bus.btn_down = down;
    repeat (hi) @(negedge clk);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic measure(input bit level, output int n);
    n = 0;
    while (bus.clk_out === level && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_mode_change(input logic [2:0] from);
    int n;
    n = 0;
    while (bus.mode === from && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  int nl, nh;
  int hold;

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // 1) idle slow period: literal timing
    for (int c = 0; c <= 90; c++) begin
      if (c == 0)  begin check("lit_c0_clk", bus.clk_out, 0); check("lit_c0_mode", bus.mode, 3'b001); end
      if (c == 29) check("lit_c29_clk", bus.clk_out, 0);
      if (c == 30) check("lit_c30_clk", bus.clk_out, 1);
      if (c == 88) check("lit_c88_pd", bus.period_done, 0);
      if (c == 89) begin check("lit_c89_pd", bus.period_done, 1); check("lit_c89_clk", bus.clk_out, 1); end
      if (c == 90) begin check("lit_c90_clk", bus.clk_out, 0); check("lit_c90_mode", bus.mode, 3'b001); end
      if (c < 90) @(negedge clk);
    end

    // 2) btn_up held: change_pending rises after E6, commit at boundary
    bus.btn_up = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) check("lit_cp_after_E5", bus.change_pending, 0);
      if (k == 7) begin check("lit_cp_after_E6", bus.change_pending, 1); check("lit_mode_held", bus.mode, 3'b001); end
    end
    bus.btn_up = 1'b0;
    wait_mode_change(3'b001);
    check("lit_commit_mid", bus.mode, 3'b010);
    check("lit_commit_clk_low", bus.clk_out, 0);
    measure(1'b0, nl); measure(1'b1, nh);
    check("lit_mid_low_len", nl, 20);
    check("lit_mid_high_len", nh, 40);

    // 3) three up presses within one slow period -> straight to fast
    do_reset();
    repeat (3) press(1'b1, 1'b0, 8, 8);
    check("lit_cp_three_ups", bus.change_pending, 1);
    wait_mode_change(3'b001);
    check("lit_commit_fast", bus.mode, 3'b100);
    measure(1'b0, nl); measure(1'b1, nh);
    check("lit_fast_low_len", nl, 10);
    check("lit_fast_high_len", nh, 20);

    // 4) glitch shorter than the debounce window is ignored
    do_reset();
    press(1'b1, 1'b0, 3, 12);
    check("lit_short_cp", bus.change_pending, 0);
    repeat (100) @(negedge clk);
    check("lit_short_mode", bus.mode, 3'b001);

    // 5) simultaneous up/down cancel; down saturates at slow
    press(1'b1, 1'b1, 8, 8);
    check("lit_both_cp", bus.change_pending, 0);
    press(1'b0, 1'b1, 8, 8);
    check("lit_down_sat_cp", bus.change_pending, 0);
    check("lit_down_sat_mode", bus.mode, 3'b001);

    // 6) reset mid-HIGH in mid mode with a pending change
    do_reset();
    press(1'b1, 1'b0, 8, 8);
    wait_mode_change(3'b001);
    press(1'b1, 1'b0, 8, 8);
    check("lit_pending_fast", bus.change_pending, 1);
    hold = 0;
    while (bus.clk_out !== 1'b1 && hold < 200) begin hold++; @(negedge clk); end
    repeat (5) @(negedge clk);
    check("lit_pre_reset_mode", bus.mode, 3'b010);
    check("lit_pre_reset_clk", bus.clk_out, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("lit_rst_mode", bus.mode, 3'b001);
    check("lit_rst_clk", bus.clk_out, 0);
    check("lit_rst_cp", bus.change_pending, 0);
    check("lit_rst_pd", bus.period_done, 0);
    measure(1'b0, nl); measure(1'b1, nh);
    check("lit_post_rst_low", nl, 30);
    check("lit_post_rst_high", nh, 60);

    // 7) randomized buttons and occasional resets vs the model
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      bus.btn_up   = ($urandom_range(0, 2) == 0);
      bus.btn_down = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 12);
      repeat (hold) @(negedge clk);
    end
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    repeat (200) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
